// File: rtl/seg_pkg.sv
// Shared constants and state encoding for the 7-segment scan controller.
package seg_pkg;

  localparam logic [3:0] CODE_OFF    = 4'd0;
  localparam logic [3:0] CODE_STABLE = 4'd10;
  localparam logic [3:0] CODE_UP     = 4'd11;
  localparam logic [3:0] CODE_DOWN   = 4'd12;

  localparam int NUM_DIGITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_DRIVE = 2'd2
  } state_e;

  // Picks one 4-bit display code out of the packed four-digit word.
  function automatic logic [3:0] digit_code(input logic [15:0] codes,
                                            input logic [1:0]  idx);
    return codes[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/slot_timer.sv
// Loadable down-counter timing one BLANK or DRIVE interval.
// done_o is high on the last cycle of the loaded interval only.
module slot_timer
  import seg_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] count_q;
  logic         run_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      count_q <= '0;
      run_q   <= 1'b0;
    end else if (load_i) begin
      count_q <= load_val_i;
      run_q   <= 1'b1;
    end else if (run_q) begin
      if (count_q == '0) run_q <= 1'b0;
      else               count_q <= count_q - 1'b1;
    end
  end

  assign done_o = run_q && (count_q == '0);

endmodule

// File: rtl/seg_scan_controller.sv
// Scans four double-buffered display codes onto a common-anode 7-segment
// display, with a blanking gap ahead of every digit to suppress ghosting.
module seg_scan_controller
  import seg_pkg::*;
#(
  parameter int DRIVE_CYCLES = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  digit_en,
  output logic [3:0]  code_out,
  output logic [3:0]  anode_n,
  output logic        frame_start,
  output logic        pending
);

  localparam int MAX_CYC = (DRIVE_CYCLES > BLANK_CYCLES) ? DRIVE_CYCLES : BLANK_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYCLES - 1);
  localparam logic [TW-1:0] DRIVE_LD = TW'(DRIVE_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] staging_q, active_q;
  logic        pending_q, frame_start_q;
  logic [3:0]  code_q, anode_q;

  logic          tmr_load, tmr_clear, tmr_done, boundary;
  logic [TW-1:0] tmr_val;

  slot_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (tmr_clear),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    tmr_load  = 1'b0;
    tmr_clear = 1'b0;
    tmr_val   = BLANK_LD;
    if (!enable) begin
      state_d   = ST_IDLE;
      idx_d     = 2'd0;
      tmr_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_BLANK;
          idx_d    = 2'd0;
          tmr_load = 1'b1;
        end
        ST_BLANK: begin
          if (tmr_done) begin
            state_d  = ST_DRIVE;
            tmr_load = 1'b1;
            tmr_val  = DRIVE_LD;
          end
        end
        ST_DRIVE: begin
          if (tmr_done) begin
            state_d  = ST_BLANK;
            idx_d    = idx_q + 2'd1;
            tmr_load = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = 2'd0;
        end
      endcase
    end
    // Frame boundary: entering BLANK of digit 0 from anywhere else.
    boundary = (state_d == ST_BLANK) && (state_q != ST_BLANK) && (idx_d == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      staging_q     <= 16'h0000;
      active_q      <= 16'h0000;
      pending_q     <= 1'b0;
      frame_start_q <= 1'b0;
      code_q        <= CODE_OFF;
      anode_q       <= 4'b1111;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      frame_start_q <= boundary;
      if (load) staging_q <= digits_in;
      // A load on the boundary cycle re-arms pending for the following frame.
      pending_q <= load | (pending_q & ~boundary);
      if (boundary && pending_q) active_q <= staging_q;
      case (state_d)
        ST_BLANK: begin
          anode_q <= 4'b1111;
          code_q  <= (boundary && pending_q) ? staging_q[3:0] : digit_code(active_q, idx_d);
        end
        ST_DRIVE: anode_q <= ~(4'(digit_en[idx_d]) << idx_d);
        default: begin
          anode_q <= 4'b1111;
          code_q  <= CODE_OFF;
        end
      endcase
    end
  end

  assign code_out    = code_q;
  assign anode_n     = anode_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench for seg_scan_controller with short slot timing.
module tb_seg_scan_controller;

  localparam int DRV  = 8;
  localparam int BLK  = 2;
  localparam int SLOT = DRV + BLK;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  digit_en = 4'hF;
  logic [3:0]  code_out, anode_n;
  logic        frame_start, pending;

  int n_pass = 0;
  int n_total = 0;
  logic [3:0] exp_q[$];

  seg_scan_controller #(.DRIVE_CYCLES(DRV), .BLANK_CYCLES(BLK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .load        (load),
    .digits_in   (digits_in),
    .digit_en    (digit_en),
    .code_out    (code_out),
    .anode_n     (anode_n),
    .frame_start (frame_start),
    .pending     (pending)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic push_frame(input logic [15:0] v);
    for (int i = 0; i < 4; i++) exp_q.push_back(v[4*i +: 4]);
  endtask

  // Checks one whole frame cycle by cycle against codes popped from the
  // scoreboard; optionally strobes load at frame-relative cycle ld_at.
  task automatic check_frame(input logic [3:0] mask, input int ld_at,
                             input logic [15:0] ld_val, input string tag);
    logic [3:0] codes[4];
    logic [3:0] ea;
    logic       ep;
    bit         found;
    int         k;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (frame_start === 1'b1) found = 1;
      else @(negedge clk);
    end
    n_total++;
    if (!found) begin
      $display("FAIL %s frame_start_wait: no pulse within 100 cycles", tag);
      return;
    end
    n_pass++;
    for (int s = 0; s < 4; s++) codes[s] = exp_q.pop_front();
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SLOT; c++) begin
        k  = s * SLOT + c;
        ea = (c < BLK || !mask[s]) ? 4'hF : ~(4'b0001 << s);
        ep = (ld_at >= 0) && (k > ld_at);
        n_total += 4;
        if (anode_n !== ea)
          $display("FAIL %s anode k=%0d got %b want %b", tag, k, anode_n, ea);
        else n_pass++;
        if (code_out !== codes[s])
          $display("FAIL %s code k=%0d got %0d want %0d", tag, k, code_out, codes[s]);
        else n_pass++;
        if (frame_start !== (k == 0))
          $display("FAIL %s frame_start k=%0d got %b want %b", tag, k, frame_start, (k == 0));
        else n_pass++;
        if (pending !== ep)
          $display("FAIL %s pending k=%0d got %b want %b", tag, k, pending, ep);
        else n_pass++;
        if (k == ld_at) begin
          load = 1'b1;
          digits_in = ld_val;
        end else load = 1'b0;
        @(negedge clk);
      end
    end
    load = 1'b0;
    n_total++;
    if (frame_start !== 1'b1)
      $display("FAIL %s period: frame_start got %b want 1 after 40 cycles", tag, frame_start);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_total += 4;
    if (anode_n !== 4'hF) $display("FAIL reset anode got %b want 1111", anode_n); else n_pass++;
    if (code_out !== 4'd0) $display("FAIL reset code got %0d want 0", code_out); else n_pass++;
    if (frame_start !== 1'b0) $display("FAIL reset frame_start got %b want 0", frame_start); else n_pass++;
    if (pending !== 1'b0) $display("FAIL reset pending got %b want 0", pending); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scan_zero();
    enable = 1'b1;
    @(negedge clk);
    n_total++;
    if (frame_start !== 1'b1) $display("FAIL enable_start frame_start got %b want 1", frame_start);
    else n_pass++;
    push_frame(16'h0000);
    check_frame(4'hF, -1, 16'h0, "zero_f1");
    push_frame(16'h0000);
    check_frame(4'hF, -1, 16'h0, "zero_f2");
  endtask

  task automatic test_load_midframe();
    push_frame(16'h0000);
    check_frame(4'hF, 15, 16'hCBA1, "mid_load");
    push_frame(16'hCBA1);
    check_frame(4'hF, -1, 16'h0, "mid_show");
  endtask

  task automatic test_load_boundary();
    push_frame(16'hCBA1);
    check_frame(4'hF, 15, 16'h1111, "bnd_stage");
    push_frame(16'h1111);
    check_frame(4'hF, 0, 16'h9876, "bnd_load");
    push_frame(16'h9876);
    check_frame(4'hF, -1, 16'h0, "bnd_next");
  endtask

  task automatic test_mask();
    digit_en = 4'b0101;
    push_frame(16'h9876);
    check_frame(4'b0101, -1, 16'h0, "mask");
    digit_en = 4'hF;
  endtask

  task automatic test_disable();
    repeat (25) @(negedge clk);
    n_total++;
    if (anode_n !== 4'b1011) $display("FAIL dis_pre anode got %b want 1011", anode_n); else n_pass++;
    enable = 1'b0;
    @(negedge clk);
    n_total += 3;
    if (anode_n !== 4'hF) $display("FAIL dis anode got %b want 1111", anode_n); else n_pass++;
    if (code_out !== 4'd0) $display("FAIL dis code got %0d want 0", code_out); else n_pass++;
    if (frame_start !== 1'b0) $display("FAIL dis frame_start got %b want 0", frame_start); else n_pass++;
    repeat (3) @(negedge clk);
    n_total++;
    if (anode_n !== 4'hF) $display("FAIL dis_hold anode got %b want 1111", anode_n); else n_pass++;
    enable = 1'b1;
    @(negedge clk);
    n_total += 2;
    if (frame_start !== 1'b1) $display("FAIL reen frame_start got %b want 1", frame_start); else n_pass++;
    if (code_out !== 4'd6) $display("FAIL reen code got %0d want 6", code_out); else n_pass++;
    push_frame(16'h9876);
    check_frame(4'hF, -1, 16'h0, "reen_frame");
  endtask

  task automatic test_passthrough();
    push_frame(16'h9876);
    check_frame(4'hF, 15, 16'hFED0, "pass_load");
    push_frame(16'hFED0);
    check_frame(4'hF, -1, 16'h0, "pass_show");
  endtask

  task automatic test_reset_mid();
    repeat (5) @(negedge clk);
    load = 1'b1;
    digits_in = 16'h4321;
    @(negedge clk);
    load = 1'b0;
    n_total++;
    if (pending !== 1'b1) $display("FAIL rmid_pend got %b want 1", pending); else n_pass++;
    rst_n = 1'b0;
    load = 1'b1;
    digits_in = 16'h5555;
    @(negedge clk);
    n_total += 4;
    if (anode_n !== 4'hF) $display("FAIL rmid anode got %b want 1111", anode_n); else n_pass++;
    if (code_out !== 4'd0) $display("FAIL rmid code got %0d want 0", code_out); else n_pass++;
    if (frame_start !== 1'b0) $display("FAIL rmid frame_start got %b want 0", frame_start); else n_pass++;
    if (pending !== 1'b0) $display("FAIL rmid pending got %b want 0", pending); else n_pass++;
    rst_n = 1'b1;
    load = 1'b0;
    push_frame(16'h0000);
    check_frame(4'hF, -1, 16'h0, "rmid_after");
  endtask

  initial begin
    test_reset();
    test_scan_zero();
    test_load_midframe();
    test_load_boundary();
    test_mask();
    test_disable();
    test_passthrough();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
